// File: rtl/muntjac_issue_scoreboard_pkg.sv
// rtl/muntjac_issue_scoreboard_pkg.sv - RISC-V base opcodes and issue classification helpers
package muntjac_issue_scoreboard_pkg;

  // 7-bit RISC-V base opcodes seen at the issue stage
  typedef enum logic [6:0] {
    OPC_LOAD      = 7'b0000011,
    OPC_MISC_MEM  = 7'b0001111,
    OPC_OP_IMM    = 7'b0010011,
    OPC_AUIPC     = 7'b0010111,
    OPC_OP_IMM_32 = 7'b0011011,
    OPC_STORE     = 7'b0100011,
    OPC_AMO       = 7'b0101111,
    OPC_OP        = 7'b0110011,
    OPC_LUI       = 7'b0110111,
    OPC_OP_32     = 7'b0111011,
    OPC_BRANCH    = 7'b1100011,
    OPC_JALR      = 7'b1100111,
    OPC_JAL       = 7'b1101111,
    OPC_SYSTEM    = 7'b1110011
  } opcode_e;

  // Width of the outstanding long-op counter (MaxPending is at most 15)
  localparam int unsigned CountW = 4;

  function automatic logic op_uses_rs1(logic [6:0] op);
    case (op)
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_OP_IMM_32, OPC_STORE,
      OPC_BRANCH, OPC_OP, OPC_OP_32, OPC_AMO: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  function automatic logic op_uses_rs2(logic [6:0] op);
    case (op)
      OPC_STORE, OPC_BRANCH, OPC_OP, OPC_OP_32, OPC_AMO: return 1'b1;
      default:                                           return 1'b0;
    endcase
  endfunction

  function automatic logic op_writes_rd(logic [6:0] op);
    case (op)
      OPC_STORE, OPC_BRANCH, OPC_MISC_MEM, OPC_SYSTEM: return 1'b0;
      default:                                         return 1'b1;
    endcase
  endfunction

  // Anything the scoreboard does not explicitly understand is treated as serializing
  function automatic logic op_is_serializing(logic [6:0] op);
    case (op)
      OPC_LOAD, OPC_OP_IMM, OPC_AUIPC, OPC_OP_IMM_32, OPC_STORE, OPC_AMO,
      OPC_OP, OPC_LUI, OPC_OP_32, OPC_BRANCH, OPC_JALR, OPC_JAL: return 1'b0;
      default:                                                  return 1'b1;
    endcase
  endfunction

  function automatic logic op_is_long(logic [6:0] op, logic muldiv);
    case (op)
      OPC_LOAD, OPC_AMO:  return 1'b1;
      OPC_OP, OPC_OP_32:  return muldiv;
      default:            return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/muntjac_issue_scoreboard.sv
// rtl/muntjac_issue_scoreboard.sv - issue-stage register hazard scoreboard with serializing drain
module muntjac_issue_scoreboard
  import muntjac_issue_scoreboard_pkg::*;
#(
  parameter int unsigned MaxPending = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        issue_valid_i,
  output logic        issue_ready_o,
  input  logic [6:0]  issue_opcode_i,
  input  logic        issue_muldiv_i,
  input  logic [4:0]  issue_rd_i,
  input  logic [4:0]  issue_rs1_i,
  input  logic [4:0]  issue_rs2_i,
  input  logic        wb_valid_i,
  input  logic [4:0]  wb_rd_i,
  output logic [31:0] pending_o,
  output logic        busy_o,
  output logic        draining_o,
  output logic        err_o
);

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [31:0]       r_pending;
  logic [CountW-1:0] r_count;
  logic              r_err;

  logic [31:0]       w_wb_onehot;
  logic [31:0]       w_eff;
  logic              w_serial;
  logic              w_long;
  logic              w_raw;
  logic              w_waw;
  logic              w_cap;
  logic              w_fire;
  logic              w_long_fire;
  logic              w_wb_dec;
  logic              w_wb_bad;
  logic [31:0]       w_set;
  logic [CountW-1:0] w_count_next;

  // A same-cycle writeback already releases its register for hazard purposes
  assign w_wb_onehot = wb_valid_i ? (32'd1 << wb_rd_i) : 32'd0;
  assign w_eff       = r_pending & ~w_wb_onehot;

  assign w_serial = op_is_serializing(issue_opcode_i);
  assign w_long   = op_is_long(issue_opcode_i, issue_muldiv_i);
  // x0 can never be set in r_pending, so no explicit x0 guard is needed on sources
  assign w_raw    = (op_uses_rs1(issue_opcode_i) && w_eff[issue_rs1_i]) ||
                    (op_uses_rs2(issue_opcode_i) && w_eff[issue_rs2_i]);
  assign w_waw    = op_writes_rd(issue_opcode_i) && (issue_rd_i != 5'd0) && w_eff[issue_rd_i];
  assign w_cap    = w_long && (r_count == CountW'(MaxPending)) && !wb_valid_i;

  // Ready: serializing ops wait for a fully quiet machine, others only for hazards
  always_comb begin
    issue_ready_o = 1'b0;
    if (w_serial) begin
      issue_ready_o = (r_count == '0) && !wb_valid_i;
    end else begin
      issue_ready_o = !(w_raw || w_waw || w_cap);
    end
  end

  assign w_fire      = issue_valid_i && issue_ready_o;
  assign w_long_fire = w_fire && w_long;
  // Counter saturates at zero; a writeback with nothing outstanding only flags an error
  assign w_wb_dec    = wb_valid_i && (r_count != '0);
  assign w_wb_bad    = wb_valid_i &&
                       ((r_count == '0) || ((wb_rd_i != 5'd0) && !r_pending[wb_rd_i]));
  assign w_set       = (w_long_fire && (issue_rd_i != 5'd0)) ? (32'd1 << issue_rd_i) : 32'd0;

  // Next outstanding count
  always_comb begin
    w_count_next = r_count;
    case ({w_long_fire, w_wb_dec})
      2'b10:   w_count_next = r_count + CountW'(1);
      2'b01:   w_count_next = r_count - CountW'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Pending bitmap, counter and sticky error; set beats clear on the same register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_pending <= 32'd0;
      r_count   <= '0;
      r_err     <= 1'b0;
    end else begin
      r_pending <= ((r_pending & ~w_wb_onehot) | w_set) & ~32'd1;
      r_count   <= w_count_next;
      if (w_wb_bad) begin
        r_err <= 1'b1;
      end
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state: enter DRAIN when a serializing op meets outstanding work
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_RUN: begin
        if (issue_valid_i && w_serial && (r_count != '0)) begin
          w_state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!issue_valid_i || (w_count_next == '0)) begin
          w_state_next = ST_RUN;
        end
      end
      default: w_state_next = ST_RUN;
    endcase
  end

  assign pending_o  = r_pending;
  assign busy_o     = (r_count != '0);
  assign draining_o = (r_state == ST_DRAIN);
  assign err_o      = r_err;

endmodule

// File: tb/tb_muntjac_issue_scoreboard.sv
// tb/tb_muntjac_issue_scoreboard.sv - table-driven bench for muntjac_issue_scoreboard
module tb_muntjac_issue_scoreboard;

  localparam logic [6:0] LOAD   = 7'h03;
  localparam logic [6:0] MISC   = 7'h0F;
  localparam logic [6:0] OPIMM  = 7'h13;
  localparam logic [6:0] STORE  = 7'h23;
  localparam logic [6:0] OP     = 7'h33;
  localparam logic [6:0] LUI    = 7'h37;
  localparam logic [6:0] SYSTEM = 7'h73;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic        ready;
  logic [6:0]  opcode;
  logic        muldiv;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] pending;
  logic        busy;
  logic        draining;
  logic        err;

  int n_checks;
  int n_errs;

  typedef struct {
    logic        v;
    logic [6:0]  op;
    logic        md;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        wv;
    logic [4:0]  wrd;
    logic        e_rdy;
    logic [31:0] e_pend;
    logic        e_busy;
    logic        e_drn;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  muntjac_issue_scoreboard #(.MaxPending(4)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .issue_valid_i  (valid),
    .issue_ready_o  (ready),
    .issue_opcode_i (opcode),
    .issue_muldiv_i (muldiv),
    .issue_rd_i     (rd),
    .issue_rs1_i    (rs1),
    .issue_rs2_i    (rs2),
    .wb_valid_i     (wb_valid),
    .wb_rd_i        (wb_rd),
    .pending_o      (pending),
    .busy_o         (busy),
    .draining_o     (draining),
    .err_o          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [6:0] op, input logic md, input logic [4:0] d,
                     input logic [4:0] s1, input logic [4:0] s2, input logic wv, input logic [4:0] wrd,
                     input logic e_rdy, input logic [31:0] e_pend, input logic e_busy,
                     input logic e_drn, input logic e_err);
    vec_t t;
    t.v = v; t.op = op; t.md = md; t.rd = d; t.rs1 = s1; t.rs2 = s2; t.wv = wv; t.wrd = wrd;
    t.e_rdy = e_rdy; t.e_pend = e_pend; t.e_busy = e_busy; t.e_drn = e_drn; t.e_err = e_err;
    vecs.push_back(t);
  endtask

  task automatic drive(input logic v, input logic [6:0] op, input logic md, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic wv, input logic [4:0] wrd);
    valid = v; opcode = op; muldiv = md; rd = d; rs1 = s1; rs2 = s2; wb_valid = wv; wb_rd = wrd;
  endtask

  initial begin
    n_checks = 0;
    n_errs   = 0;
    rst_n    = 1'b0;
    drive(1'b0, OPIMM, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 5'd0);

    // LOAD x5 then dependent OP released by same-cycle writeback
    add(1, LOAD,   0, 5, 1, 0, 0, 0, 1, 32'h20, 1, 0, 0);
    add(1, OP,     0, 10, 5, 0, 0, 0, 0, 32'h20, 1, 0, 0);
    add(1, OP,     0, 10, 5, 0, 1, 5, 1, 32'h0,  0, 0, 0);
    // WAW stall on LUI, independent STORE issues
    add(1, LOAD,   0, 5, 0, 0, 0, 0, 1, 32'h20, 1, 0, 0);
    add(1, LUI,    0, 5, 0, 0, 0, 0, 0, 32'h20, 1, 0, 0);
    add(1, STORE,  0, 5, 6, 7, 0, 0, 1, 32'h20, 1, 0, 0);
    add(0, OPIMM,  0, 0, 0, 0, 1, 5, 1, 32'h0,  0, 0, 0);
    // Capacity: four loads, fifth waits for a writeback and fires with it
    add(1, LOAD,   0, 1, 0, 0, 0, 0, 1, 32'h2,   1, 0, 0);
    add(1, LOAD,   0, 2, 0, 0, 0, 0, 1, 32'h6,   1, 0, 0);
    add(1, LOAD,   0, 3, 0, 0, 0, 0, 1, 32'hE,   1, 0, 0);
    add(1, LOAD,   0, 4, 0, 0, 0, 0, 1, 32'h1E,  1, 0, 0);
    add(1, LOAD,   0, 8, 0, 0, 0, 0, 0, 32'h1E,  1, 0, 0);
    add(1, LOAD,   0, 8, 0, 0, 1, 1, 1, 32'h11C, 1, 0, 0);
    add(0, OPIMM,  0, 0, 0, 0, 1, 2, 1, 32'h118, 1, 0, 0);
    add(0, OPIMM,  0, 0, 0, 0, 1, 3, 1, 32'h110, 1, 0, 0);
    add(0, OPIMM,  0, 0, 0, 0, 1, 4, 1, 32'h100, 1, 0, 0);
    add(0, OPIMM,  0, 0, 0, 0, 1, 8, 1, 32'h0,   0, 0, 0);
    // SYSTEM drains two outstanding loads, then fires one cycle after count hits 0
    add(1, LOAD,   0, 1, 0, 0, 0, 0, 1, 32'h2, 1, 0, 0);
    add(1, LOAD,   0, 2, 0, 0, 0, 0, 1, 32'h6, 1, 0, 0);
    add(1, SYSTEM, 0, 0, 0, 0, 0, 0, 0, 32'h6, 1, 1, 0);
    add(1, SYSTEM, 0, 0, 0, 0, 1, 1, 0, 32'h4, 1, 1, 0);
    add(1, SYSTEM, 0, 0, 0, 0, 1, 2, 0, 32'h0, 0, 0, 0);
    add(1, SYSTEM, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0);
    // Fence with nothing outstanding issues at once
    add(1, MISC,   0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0, 0);
    // LOAD to x0 only counts
    add(1, LOAD,   0, 0, 0, 0, 0, 0, 1, 32'h0, 1, 0, 0);
    add(1, OP,     0, 3, 0, 0, 0, 0, 1, 32'h0, 1, 0, 0);
    add(0, OPIMM,  0, 0, 0, 0, 1, 0, 1, 32'h0, 0, 0, 0);
    // mul/div is long; plain OP to same rd sees WAW
    add(1, OP,     1, 7, 0, 0, 0, 0, 1, 32'h80, 1, 0, 0);
    add(1, OP,     0, 7, 0, 0, 0, 0, 0, 32'h80, 1, 0, 0);
    add(0, OPIMM,  0, 0, 0, 0, 1, 7, 1, 32'h0,  0, 0, 0);
    // Dropping valid during DRAIN returns to RUN
    add(1, LOAD,   0, 1, 0, 0, 0, 0, 1, 32'h2, 1, 0, 0);
    add(1, SYSTEM, 0, 0, 0, 0, 0, 0, 0, 32'h2, 1, 1, 0);
    add(0, OPIMM,  0, 0, 0, 0, 0, 0, 1, 32'h2, 1, 0, 0);
    add(0, OPIMM,  0, 0, 0, 0, 1, 1, 1, 32'h0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    check("reset pending", pending, 32'h0);
    check("reset busy", {31'd0, busy}, 32'd0);
    check("reset draining", {31'd0, draining}, 32'd0);
    check("reset err", {31'd0, err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].v, vecs[i].op, vecs[i].md, vecs[i].rd, vecs[i].rs1, vecs[i].rs2,
            vecs[i].wv, vecs[i].wrd);
      #1;
      check($sformatf("v%0d ready", i), {31'd0, ready}, {31'd0, vecs[i].e_rdy});
      @(posedge clk);
      #1;
      check($sformatf("v%0d pending", i), pending, vecs[i].e_pend);
      check($sformatf("v%0d busy", i), {31'd0, busy}, {31'd0, vecs[i].e_busy});
      check($sformatf("v%0d draining", i), {31'd0, draining}, {31'd0, vecs[i].e_drn});
      check($sformatf("v%0d err", i), {31'd0, err}, {31'd0, vecs[i].e_err});
    end

    // Spurious writeback raises a sticky error
    @(negedge clk); drive(0, OPIMM, 0, 0, 0, 0, 1, 9);
    @(posedge clk); #1;
    check("spurious wb err", {31'd0, err}, 32'd1);
    @(negedge clk); drive(0, OPIMM, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("err sticky", {31'd0, err}, 32'd1);
    check("err no count", {31'd0, busy}, 32'd0);

    // Enter DRAIN, then reset asynchronously in the middle of a low phase
    @(negedge clk); drive(1, LOAD, 0, 1, 0, 0, 0, 0);
    @(negedge clk); drive(1, LOAD, 0, 2, 0, 0, 0, 0);
    @(negedge clk); drive(1, SYSTEM, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    check("pre-reset draining", {31'd0, draining}, 32'd1);
    check("pre-reset pending", pending, 32'h6);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async rst pending", pending, 32'h0);
    check("async rst busy", {31'd0, busy}, 32'd0);
    check("async rst draining", {31'd0, draining}, 32'd0);
    check("async rst err", {31'd0, err}, 32'd0);
    drive(0, OPIMM, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Writeback of a pre-reset load is now an error
    @(negedge clk); drive(0, OPIMM, 0, 0, 0, 0, 1, 1);
    @(posedge clk); #1;
    check("post-reset wb err", {31'd0, err}, 32'd1);
    check("post-reset pending", pending, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/muntjac_issue_scoreboard.md
Name: muntjac_issue_scoreboard

Overview:
- Issue-stage hazard controller between decode and execute.
- Tracks destination registers of in-flight long-latency instructions (LOAD, AMO, mul/div) and stalls any instruction that reads or overwrites a pending register.
- Drains all outstanding long-latency operations before serializing opcodes (MISC_MEM, SYSTEM, unknown) issue.
- Classifies operands purely from the 7-bit base opcode (opcode_e) plus a mul/div flag from decode.

Parameters:
- MaxPending, 4, maximum outstanding long-latency ops (1..15); issue of a further long op stalls when reached.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- issue_valid_i  in  1  decode presents an instruction
- issue_ready_o  out  1  instruction may issue this cycle; fire = valid & ready
- issue_opcode_i  in  7  base opcode (opcode_e)
- issue_muldiv_i  in  1  OP/OP_32 instruction is mul/div (long latency)
- issue_rd_i  in  5  destination register
- issue_rs1_i  in  5  source register 1
- issue_rs2_i  in  5  source register 2
- wb_valid_i  in  1  long-latency result written back this cycle
- wb_rd_i  in  5  register written back
- pending_o  out  32  per-register pending bitmap; bit 0 always 0
- busy_o  out  1  outstanding count != 0
- draining_o  out  1  FSM in DRAIN
- err_o  out  1  sticky: writeback to a non-pending register, or count underflow

Behaviour:
- Reset (async, rst_ni low): pending_o = 0, count = 0, FSM = RUN, err_o = 0, busy_o = 0, draining_o = 0.
- issue_ready_o is combinational.

Opcode classes:
- rs1 used: JALR, LOAD, OP_IMM, OP_IMM_32, STORE, BRANCH, OP, OP_32, AMO.
- rs2 used: STORE, BRANCH, OP, OP_32, AMO.
- No sources: LUI, AUIPC, JAL.
- Writes rd: all except STORE, BRANCH, MISC_MEM, SYSTEM.
- Long: LOAD, AMO, or (OP/OP_32 & issue_muldiv_i).
- Serializing: MISC_MEM, SYSTEM, any other encoding.
- Register x0 is never pending and never causes a hazard.

Effective pending:
- eff = pending_o & ~(wb_valid_i ? onehot(wb_rd_i) : 0). Same-cycle writeback releases the hazard.

Hazards:
- RAW: a used rs is set in eff.
- WAW: the instruction writes rd != 0 and eff[rd] is set.
- Capacity: long op and count == MaxPending, and no writeback this cycle.

issue_ready_o:
- RUN state, non-serializing instruction: ready = ~hazard.
- Serializing instruction: ready = (count == 0) & ~(wb_valid_i pending).
- A serializing instruction seen while count != 0 moves the FSM RUN -> DRAIN; ready stays 0.
- DRAIN -> RUN on the cycle count reaches 0; the serializing op fires the following cycle.
- Decode holds valid and all fields stable until fire. Dropping valid in DRAIN returns the FSM to RUN.

Update on clock edge:
- Fire of a long op with rd != 0 sets pending[rd].
- Long op with rd == 0 increments count only.
- wb_valid_i clears pending[wb_rd_i].
- Set and clear of the same rd in the same cycle: set wins.
- count +1 on long fire, -1 on wb, unchanged if both.
- wb_valid_i with count == 0, or with wb_rd_i != 0 not pending: err_o <= 1 (sticky until reset); count saturates at 0.
- Reset mid-drain or with pending entries discards all state; the bench must not expect writebacks after reset to be accepted silently.

Decomposition:
- Extend the shared riscv package with pure functions on opcode_e:
  - op_uses_rs1
  - op_uses_rs2
  - op_writes_rd
  - op_is_serializing
  - op_is_long(opcode, muldiv)
- FSM state enum (RUN, DRAIN) stays local to the module.
- No sub-module; bitmap, counter and FSM are small enough to live in one module.

Test Plan:
- LOAD rd=5 fires -> pending_o=0x20, busy_o=1. Next cycle OP rs1=5 is stalled (ready=0). Assert wb_valid_i, wb_rd_i=5 that cycle -> OP fires same cycle; pending_o=0 after the edge.
- LUI rd=5 while x5 pending -> WAW stall. STORE rs1=6, rs2=7 with x5 pending -> issues immediately.
- Four LOADs to x1..x4 (MaxPending=4); fifth LOAD x8 -> stalled until any writeback, then fires in the writeback cycle; count stays 4.
- SYSTEM with 2 pending -> draining_o=1, ready=0. After two writebacks -> FSM RUN, SYSTEM fires one cycle later, count 0.
- LOAD rd=0 -> pending_o stays 0, busy_o=1. OP rs1=0 issues without stall. Writeback wb_rd_i=0 -> busy_o=0, err_o=0.
- Writeback to x9 with nothing pending -> err_o=1 and stays set. Assert rst_ni low mid-DRAIN -> all outputs return to 0 asynchronously.
